median_seq_ctrl: RTL and testbench
==================================

# median_seq_ctrl

Avalon-MM slave controller that sequences a 5-tap median-filter engine over a buffered sample stream. Software loads up to 16 8-bit samples and a length, then writes START. The block slides a 5-sample window across the buffer, issues each window to the engine over a start/done handshake, and stores each median in a result buffer. It sits between the Avalon bus and the median datapath and owns all sequencing, status, timeout and interrupt logic.

## Interface
- TIMEOUT, 255: maximum cycles spent waiting for engine done per window before the run is aborted with an error.
- iClk  in  1  clock; all logic on rising edge.
- iReset_n  in  1  asynchronous, active-low reset.
- iChipSelect_n  in  1  Avalon chip select, active low.
- iWrite_n  in  1  Avalon write strobe, active low.
- iRead_n  in  1  Avalon read strobe, active low.
- iAddress  in  6  word address (map below).
- iData  in  32  write data.
- oData  out  32  registered read data.
- oIrq  out  1  level interrupt = DONE & IRQ_EN.
- oEngStart  out  1  one-cycle pulse: window valid on oEngWin.
- oEngWin  out  40  window, sample k+i in bits [8i+7:8i], i=0..4.
- iEngDone  in  1  one-cycle pulse: iEngMedian valid.
- iEngMedian  in  8  median result from engine.

## Operation
- Address map:
  - 0x00–0x0F: SAMPLE[0..15]. Write uses iData[7:0]. Reads return 0.
  - 0x10–0x1F: RESULT[0..15]. Read-only, {24'd0, value}.
  - 0x20: CTRL. Write bit0 = START (self-clearing), bit1 = ABORT (self-clearing), bit2 = IRQ_EN (stored). Reads return {29'd0, IRQ_EN, 2'b00}.
  - 0x21: STATUS. Read returns {23'd0, COUNT[4:0], ERR_TO, ERR_LEN, DONE, BUSY}. Writing 1 to bit1/2/3 clears DONE/ERR_LEN/ERR_TO.
  - 0x22: LEN. Bits [4:0] are writable. Read returns {27'd0, LEN}.
  - Any other address: writes are ignored; reads return 0.
- While BUSY:
  - Writes to SAMPLE and LEN are ignored.
  - START is ignored.
  - ABORT is honoured.
- START when idle:
  - If LEN < 5 or LEN > 16: set ERR_LEN and do not run.
  - Otherwise: clear DONE, ERR_TO, COUNT and the window index k; set BUSY.
- FSM states:
  - IDLE: wait for a valid START, then go to ISSUE.
  - ISSUE: drive oEngStart=1 and oEngWin=SAMPLE[k..k+4]; clear the timeout counter; go to WAIT.
  - WAIT: on iEngDone, latch iEngMedian and go to STORE. Increment the counter each cycle; when it reaches TIMEOUT, set ERR_TO and go to IDLE.
  - STORE: RESULT[k] <= latched median; COUNT++. If k == LEN-5, go to FIN; otherwise k++ and go to ISSUE.
  - FIN: set DONE, clear BUSY, go to IDLE.
- Number of windows = LEN-4. RESULT entries at index ≥ LEN-4 keep their old values.
- iEngDone is accepted only in WAIT; it is ignored in every other state.
- oEngWin holds its last value outside ISSUE.
- ABORT while BUSY: go to IDLE on the next edge, clear BUSY, leave DONE clear. COUNT and RESULT keep their partial contents.
- ABORT has priority over iEngDone in the same cycle.
- A write to STATUS in the same cycle that DONE/ERR is set: the set wins.
- Reset state:
  - All outputs are 0: oData, oIrq, oEngStart, oEngWin.
  - FSM in IDLE.
  - LEN, IRQ_EN, status bits, COUNT and k are 0.
  - SAMPLE and RESULT arrays are cleared to 0.
- Reset mid-run returns to the reset state immediately (asynchronous).

## Timing
- Register write takes effect at the edge where the write is sampled.
- Read: oData updates at the edge where the read is sampled, giving 1-cycle latency. oData holds its value when there is no read.
- START sampled at edge T: BUSY=1 and oEngStart=1 in cycle T+1.
- Engine latency L ≥ 1 (iEngDone L cycles after oEngStart): each window costs L+2 cycles.
- Full run time: START edge to DONE=1 is (LEN-4)(L+2)+1 cycles.
- oIrq is asserted the same cycle DONE rises, if IRQ_EN=1.
- Timeout: ERR_TO is set TIMEOUT cycles after ISSUE if no iEngDone arrives.

## Test plan
- Nominal run:
  - Stimulus: SAMPLE = 10,50,20,40,30,60,5; LEN=7; START; model engine with L=3 returning the true median.
  - Required: RESULT[0..2] = 30,40,30; COUNT=3; DONE=1, BUSY=0; DONE exactly 16 cycles after the START edge; exactly 3 oEngStart pulses.
- Length error: LEN=4, START.
  - Required: ERR_LEN=1; no oEngStart pulse; BUSY stays 0.
  - Repeat with LEN=17: same response.
- Timeout: engine never answers, TIMEOUT=255.
  - Required: ERR_TO=1 and BUSY=0 exactly 256 cycles after START; DONE=0.
- Abort: ABORT written during WAIT of window 1, LEN=8.
  - Required: BUSY=0 next cycle; COUNT=1; DONE=0.
  - Also: an iEngDone in the same cycle as ABORT is not stored.
- Busy protection and interrupt: during a run, write SAMPLE[0]=0xFF, write LEN=5, issue START again.
  - Required: none of these take effect; results match the unmodified data.
  - With IRQ_EN=1: oIrq rises with DONE; writing STATUS=0x2 drops oIrq next cycle.
- Async reset mid-run: assert iReset_n=0 during WAIT.
  - Required: all outputs and status are 0 immediately; after release, the block is in IDLE and accepts a new START.

Source files
------------

// File: rtl/median_seq_ctrl.sv
// Avalon-MM sequencer sliding a 5-tap window over a 16-sample buffer into a median engine.
// Latency: L+2 cycles per window, 1-cycle registered reads; engine backpressure is absorbed in WAIT, bounded by TIMEOUT.
module median_seq_ctrl #(
  parameter int TIMEOUT = 255
) (
  input  logic        iClk,
  input  logic        iReset_n,
  input  logic        iChipSelect_n,
  input  logic        iWrite_n,
  input  logic        iRead_n,
  input  logic [5:0]  iAddress,
  input  logic [31:0] iData,
  output logic [31:0] oData,
  output logic        oIrq,
  output logic        oEngStart,
  output logic [39:0] oEngWin,
  input  logic        iEngDone,
  input  logic [7:0]  iEngMedian
);

  typedef enum logic [2:0] {S_IDLE, S_ISSUE, S_WAIT, S_STORE, S_FIN} state_t;

  state_t      state_q, state_d;
  logic [7:0]  sample_q [16];
  logic [7:0]  sample_d [16];
  logic [7:0]  result_q [16];
  logic [7:0]  result_d [16];
  logic [4:0]  len_q, len_d;
  logic        irq_en_q, irq_en_d;
  logic        done_q, done_d;
  logic        err_len_q, err_len_d;
  logic        err_to_q, err_to_d;
  logic [4:0]  count_q, count_d;
  logic [3:0]  k_q, k_d;
  logic [7:0]  to_cnt_q, to_cnt_d;
  logic [7:0]  med_q, med_d;
  logic [39:0] win_q, win_d;
  logic [31:0] data_q, data_d;

  logic        wr, rd, busy, ctrl_wr, start_req, abort_req, len_ok, start_ok;
  logic        last_win, to_hit;
  logic [7:0]  to_next;
  logic [39:0] cur_win;
  logic        unused_dat;

  assign unused_dat = ^iData[31:8];
  assign wr        = !iChipSelect_n && !iWrite_n;
  assign rd        = !iChipSelect_n && !iRead_n;
  assign ctrl_wr   = wr && (iAddress == 6'h20);
  assign start_req = ctrl_wr && iData[0] && !busy;
  assign abort_req = ctrl_wr && iData[1] && busy;
  assign len_ok    = (len_q >= 5'd5) && (len_q <= 5'd16);
  assign start_ok  = start_req && len_ok;
  assign last_win  = ({1'b0, k_q} == (len_q - 5'd5));
  assign to_next   = to_cnt_q + 8'd1;
  assign to_hit    = (to_next == 8'(TIMEOUT));
  assign oIrq      = done_q && irq_en_q;
  assign oData     = data_q;

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  // ABORT overrides everything, including an engine answer in the same cycle
  always_comb begin
    state_d = state_q;
    if (abort_req) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE:  if (start_ok) state_d = S_ISSUE;
        S_ISSUE: state_d = S_WAIT;
        S_WAIT:  if (iEngDone) state_d = S_STORE;
                 else if (to_hit) state_d = S_IDLE;
        S_STORE: state_d = last_win ? S_FIN : S_ISSUE;
        S_FIN:   state_d = S_IDLE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    cur_win = '0;
    for (int i = 0; i < 5; i++) cur_win[8*i +: 8] = sample_q[k_q + 4'(i)];
    busy      = (state_q != S_IDLE);
    oEngStart = (state_q == S_ISSUE);
    oEngWin   = oEngStart ? cur_win : win_q;
  end

  always_comb begin
    sample_d  = sample_q;
    result_d  = result_q;
    len_d     = len_q;
    irq_en_d  = irq_en_q;
    done_d    = done_q;
    err_len_d = err_len_q;
    err_to_d  = err_to_q;
    count_d   = count_q;
    k_d       = k_q;
    to_cnt_d  = to_cnt_q;
    med_d     = med_q;
    win_d     = win_q;
    data_d    = data_q;

    if (wr && !busy && (iAddress[5:4] == 2'b00)) sample_d[iAddress[3:0]] = iData[7:0];
    if (wr && !busy && (iAddress == 6'h22)) len_d = iData[4:0];
    if (ctrl_wr) irq_en_d = iData[2];
    if (wr && (iAddress == 6'h21)) begin
      if (iData[1]) done_d    = 1'b0;
      if (iData[2]) err_len_d = 1'b0;
      if (iData[3]) err_to_d  = 1'b0;
    end
    if (start_req && !len_ok) err_len_d = 1'b1;
    if (start_ok) begin
      done_d   = 1'b0;
      err_to_d = 1'b0;
      count_d  = '0;
      k_d      = '0;
    end

    // status sets come after the software clears so that a same-cycle set wins
    if (!abort_req) begin
      case (state_q)
        S_ISSUE: begin
          to_cnt_d = '0;
          win_d    = cur_win;
        end
        S_WAIT: begin
          if (iEngDone) begin
            med_d = iEngMedian;
          end else begin
            to_cnt_d = to_next;
            if (to_hit) err_to_d = 1'b1;
          end
        end
        S_STORE: begin
          result_d[k_q] = med_q;
          count_d       = count_q + 5'd1;
          if (!last_win) k_d = k_q + 4'd1;
        end
        S_FIN:   done_d = 1'b1;
        default: ;
      endcase
    end

    if (rd) begin
      data_d = '0;
      if (iAddress[5:4] == 2'b01) begin
        data_d = {24'd0, result_q[iAddress[3:0]]};
      end else begin
        case (iAddress)
          6'h20:   data_d = {29'd0, irq_en_q, 2'b00};
          6'h21:   data_d = {23'd0, count_q, err_to_q, err_len_q, done_q, busy};
          6'h22:   data_d = {27'd0, len_q};
          default: data_d = '0;
        endcase
      end
    end
  end

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      for (int i = 0; i < 16; i++) begin
        sample_q[i] <= '0;
        result_q[i] <= '0;
      end
      len_q     <= '0;
      irq_en_q  <= 1'b0;
      done_q    <= 1'b0;
      err_len_q <= 1'b0;
      err_to_q  <= 1'b0;
      count_q   <= '0;
      k_q       <= '0;
      to_cnt_q  <= '0;
      med_q     <= '0;
      win_q     <= '0;
      data_q    <= '0;
    end else begin
      sample_q  <= sample_d;
      result_q  <= result_d;
      len_q     <= len_d;
      irq_en_q  <= irq_en_d;
      done_q    <= done_d;
      err_len_q <= err_len_d;
      err_to_q  <= err_to_d;
      count_q   <= count_d;
      k_q       <= k_d;
      to_cnt_q  <= to_cnt_d;
      med_q     <= med_d;
      win_q     <= win_d;
      data_q    <= data_d;
    end
  end

endmodule

// File: tb/tb_median_seq_ctrl.sv
// Directed bench for median_seq_ctrl: nominal run, length errors, timeout, abort,
// busy protection with interrupt, and asynchronous reset mid-run.
module tb_median_seq_ctrl;

  logic        iClk = 1'b0;
  logic        iReset_n;
  logic        iChipSelect_n, iWrite_n, iRead_n;
  logic [5:0]  iAddress;
  logic [31:0] iData;
  logic [31:0] oData;
  logic        oIrq, oEngStart;
  logic [39:0] oEngWin;
  logic        iEngDone;
  logic [7:0]  iEngMedian;

  logic        eng_en, eng_done, man_done;
  logic [7:0]  eng_med, man_med;
  int          eng_lat;
  int          n_starts;
  int          n_checks, n_errors;

  assign iEngDone   = eng_done | man_done;
  assign iEngMedian = man_done ? man_med : eng_med;

  always #5 iClk = ~iClk;

  median_seq_ctrl #(.TIMEOUT(255)) dut (
    .iClk(iClk), .iReset_n(iReset_n), .iChipSelect_n(iChipSelect_n),
    .iWrite_n(iWrite_n), .iRead_n(iRead_n), .iAddress(iAddress), .iData(iData),
    .oData(oData), .oIrq(oIrq), .oEngStart(oEngStart), .oEngWin(oEngWin),
    .iEngDone(iEngDone), .iEngMedian(iEngMedian)
  );

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  function automatic logic [7:0] med5(input logic [39:0] w);
    logic [7:0] a [5];
    logic [7:0] t;
    for (int i = 0; i < 5; i++) a[i] = w[8*i +: 8];
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4 - i; j++)
        if (a[j] > a[j+1]) begin
          t = a[j]; a[j] = a[j+1]; a[j+1] = t;
        end
    return a[2];
  endfunction

  // Bus tasks are entered at a negedge and return at the following negedge
  task automatic bus_wr(input logic [5:0] a, input logic [31:0] d);
    iChipSelect_n = 1'b0; iWrite_n = 1'b0; iAddress = a; iData = d;
    @(negedge iClk);
    iChipSelect_n = 1'b1; iWrite_n = 1'b1;
  endtask

  task automatic bus_rd(input logic [5:0] a, output logic [31:0] d);
    iChipSelect_n = 1'b0; iRead_n = 1'b0; iAddress = a;
    @(negedge iClk);
    iChipSelect_n = 1'b1; iRead_n = 1'b1;
    d = oData;
  endtask

  task automatic wait_irq(output int cyc);
    cyc = 0;
    while (!oIrq && cyc < 400) begin
      @(negedge iClk);
      cyc++;
    end
  endtask

  task automatic load_nominal();
    logic [7:0] s [7];
    s = '{8'd10, 8'd50, 8'd20, 8'd40, 8'd30, 8'd60, 8'd5};
    for (int i = 0; i < 7; i++) bus_wr(6'(i), {24'd0, s[i]});
    bus_wr(6'h22, 32'd7);
  endtask

  // Engine model: answers L cycles after each start pulse with the true median
  initial begin
    eng_done = 1'b0;
    eng_med  = '0;
    forever begin
      @(negedge iClk);
      if (oEngStart && eng_en) begin
        logic [7:0] m;
        m = med5(oEngWin);
        repeat (eng_lat) @(negedge iClk);
        eng_done = 1'b1;
        eng_med  = m;
        @(negedge iClk);
        eng_done = 1'b0;
      end
    end
  end

  initial begin
    n_starts = 0;
    forever begin
      @(negedge iClk);
      if (oEngStart) n_starts++;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] rd;
    int cyc, s0;
    n_checks = 0; n_errors = 0;
    iReset_n = 1'b0; iChipSelect_n = 1'b1; iWrite_n = 1'b1; iRead_n = 1'b1;
    iAddress = '0; iData = '0;
    man_done = 1'b0; man_med = '0; eng_en = 1'b1; eng_lat = 3;

    // reset state
    repeat (3) @(negedge iClk);
    check("rst_odata", oData, 0);
    check("rst_irq", oIrq, 0);
    check("rst_start", oEngStart, 0);
    check("rst_win", oEngWin, 0);
    iReset_n = 1'b1;
    @(negedge iClk);
    bus_rd(6'h21, rd); check("rst_status", rd, 0);
    bus_rd(6'h22, rd); check("rst_len", rd, 0);
    bus_rd(6'h20, rd); check("rst_ctrl", rd, 0);
    bus_rd(6'h10, rd); check("rst_result0", rd, 0);

    // nominal run, L=3, IRQ enabled so DONE is visible on oIrq
    load_nominal();
    s0 = n_starts;
    bus_wr(6'h20, 32'h5);
    wait_irq(cyc);
    check("nom_done_latency", cyc, 16);
    check("nom_starts", n_starts - s0, 3);
    bus_rd(6'h10, rd); check("nom_result0", rd, 30);
    bus_rd(6'h11, rd); check("nom_result1", rd, 40);
    bus_rd(6'h12, rd); check("nom_result2", rd, 30);
    bus_rd(6'h13, rd); check("nom_result3_untouched", rd, 0);
    bus_rd(6'h21, rd); check("nom_status", rd, 32'h32);
    bus_rd(6'h20, rd); check("nom_ctrl", rd, 32'h4);
    bus_rd(6'h00, rd); check("sample_reads_zero", rd, 0);
    bus_rd(6'h30, rd); check("unmapped_read", rd, 0);
    check("nom_irq_high", oIrq, 1);
    bus_wr(6'h21, 32'h2);
    check("nom_irq_cleared", oIrq, 0);

    // length errors
    bus_wr(6'h22, 32'd4);
    s0 = n_starts;
    bus_wr(6'h20, 32'h5);
    repeat (5) @(negedge iClk);
    check("len4_starts", n_starts - s0, 0);
    bus_rd(6'h21, rd); check("len4_status", rd, 32'h34);
    bus_wr(6'h21, 32'h4);
    bus_wr(6'h22, 32'd17);
    bus_rd(6'h22, rd); check("len17_readback", rd, 17);
    bus_wr(6'h20, 32'h5);
    repeat (5) @(negedge iClk);
    check("len17_starts", n_starts - s0, 0);
    bus_rd(6'h21, rd); check("len17_status", rd, 32'h34);
    bus_wr(6'h21, 32'h4);

    // timeout: engine silent; ERR_TO lands at the 256th edge after START
    eng_en = 1'b0;
    bus_wr(6'h22, 32'd5);
    s0 = n_starts;
    bus_wr(6'h20, 32'h5);
    repeat (255) @(negedge iClk);
    bus_rd(6'h21, rd); check("to_before_edge", rd, 32'h01);
    bus_rd(6'h21, rd); check("to_after_edge", rd, 32'h08);
    check("to_starts", n_starts - s0, 1);
    check("to_irq", oIrq, 0);
    bus_wr(6'h21, 32'h8);

    // abort in WAIT of window 1 with a same-cycle engine answer
    bus_wr(6'h07, 32'd70);
    bus_wr(6'h22, 32'd8);
    s0 = n_starts;
    bus_wr(6'h20, 32'h5);
    @(negedge iClk);
    man_done = 1'b1; man_med = 8'h77;
    @(negedge iClk);
    man_done = 1'b0;
    @(negedge iClk);
    @(negedge iClk);
    man_done = 1'b1; man_med = 8'h99;
    bus_wr(6'h20, 32'h6);
    man_done = 1'b0;
    bus_rd(6'h21, rd); check("abort_status", rd, 32'h10);
    bus_rd(6'h10, rd); check("abort_result0", rd, 32'h77);
    bus_rd(6'h11, rd); check("abort_result1_kept", rd, 40);
    check("abort_starts", n_starts - s0, 2);

    // busy protection: writes during the run must not take effect
    eng_en = 1'b1;
    bus_wr(6'h22, 32'd7);
    s0 = n_starts;
    bus_wr(6'h20, 32'h5);
    bus_wr(6'h00, 32'hFF);
    bus_wr(6'h03, 32'hFF);
    bus_wr(6'h22, 32'd5);
    bus_wr(6'h20, 32'h5);
    wait_irq(cyc);
    check("busy_done_latency", cyc, 12);
    check("busy_starts", n_starts - s0, 3);
    bus_rd(6'h10, rd); check("busy_result0", rd, 30);
    bus_rd(6'h11, rd); check("busy_result1", rd, 40);
    bus_rd(6'h12, rd); check("busy_result2", rd, 30);
    bus_rd(6'h22, rd); check("busy_len", rd, 7);
    bus_rd(6'h21, rd); check("busy_status", rd, 32'h32);
    check("busy_irq_high", oIrq, 1);
    bus_wr(6'h21, 32'h2);
    check("busy_irq_cleared", oIrq, 0);

    // asynchronous reset during WAIT
    bus_wr(6'h20, 32'h5);
    bus_rd(6'h22, rd); check("arst_pre_read", rd, 7);
    check("arst_pre_win", oEngWin, {8'd30, 8'd40, 8'd20, 8'd50, 8'd10});
    #1 iReset_n = 1'b0;
    #1;
    check("arst_odata", oData, 0);
    check("arst_irq", oIrq, 0);
    check("arst_start", oEngStart, 0);
    check("arst_win", oEngWin, 0);
    repeat (5) @(negedge iClk);
    iReset_n = 1'b1;
    @(negedge iClk);
    bus_rd(6'h21, rd); check("arst_status", rd, 0);
    bus_rd(6'h22, rd); check("arst_len", rd, 0);
    bus_rd(6'h11, rd); check("arst_result1", rd, 0);
    load_nominal();
    s0 = n_starts;
    bus_wr(6'h20, 32'h5);
    wait_irq(cyc);
    check("arst_rerun_latency", cyc, 16);
    check("arst_rerun_starts", n_starts - s0, 3);
    bus_rd(6'h11, rd); check("arst_rerun_result1", rd, 40);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
